// File: rtl/sampled_value_chk_if.sv
// sampled_value_chk_if
// Groups the evaluation inputs and result outputs of sampled_value_chk.
// Optional macro: SAMPLED_VALUE_CHK_STATS_EN adds the cnt_clr / fail_cnt pair
// and the CNT_W parameter.
//   en        per-channel evaluation enable
//   mode      function select: 00 rose, 01 fell, 10 stable, 11 changed
//   signal_in monitored signals, one bit per channel
//   match     per-channel pass pulse
//   fail      per-channel fail pulse
//   any_fail  OR of fail, same timing as fail
//   warm      history holds DEPTH+1 real samples
//   cnt_clr   (stats only) synchronous clear of fail_cnt
//   fail_cnt  (stats only) saturating count of any_fail cycles
// Modports: master drives the inputs (stimulus side), slave is the checker.
interface sampled_value_chk_if #(
    parameter int WIDTH = 8
`ifdef SAMPLED_VALUE_CHK_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
);
    logic [WIDTH-1:0] en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] signal_in;
    logic [WIDTH-1:0] match;
    logic [WIDTH-1:0] fail;
    logic             any_fail;
    logic             warm;
`ifdef SAMPLED_VALUE_CHK_STATS_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        output en, mode, signal_in, cnt_clr,
        input  match, fail, any_fail, warm, fail_cnt
    );
    modport slave (
        input  en, mode, signal_in, cnt_clr,
        output match, fail, any_fail, warm, fail_cnt
    );
`else
    modport master (
        output en, mode, signal_in,
        input  match, fail, any_fail, warm
    );
    modport slave (
        input  en, mode, signal_in,
        output match, fail, any_fail, warm
    );
`endif
endinterface

// File: rtl/sampled_value_chk.sv
// sampled_value_chk
// Multi-channel checker for the sampled-value functions $rose, $fell,
// $stable and $changed. Each channel's newest sample is compared with the
// sample taken DEPTH clocks earlier (as $past(x,DEPTH)), and registered
// per-channel match/fail pulses are produced, gated by per-channel enables.
// Result of a sample taken at edge t is visible after edge t+1 for any DEPTH.
// Optional macro: SAMPLED_VALUE_CHK_STATS_EN adds a saturating fail counter
// (CNT_W bits) with a synchronous clear.
// Ports:
//   clk     clock, all state updates on posedge
//   rst     asynchronous reset, active-high
//   chk_if  slave modport of sampled_value_chk_if (en, mode, signal_in in;
//           match, fail, any_fail, warm out; cnt_clr/fail_cnt with stats)
module sampled_value_chk #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
`ifdef SAMPLED_VALUE_CHK_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    sampled_value_chk_if.slave   chk_if
);

    localparam int FillW = $clog2(DEPTH + 2);
    localparam logic [FillW-1:0] FillMax = FillW'(DEPTH + 1);

    logic [WIDTH-1:0] hist_q [0:DEPTH];
    logic [WIDTH-1:0] enSampled_q;
    logic [1:0]       modeSampled_q;
    logic [FillW-1:0] fillCnt_q;
    logic [FillW-1:0] fillCnt_d;
    logic             warm;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] past;
    logic [WIDTH-1:0] funcHit;
    logic [WIDTH-1:0] match_d;
    logic [WIDTH-1:0] fail_d;
    logic [WIDTH-1:0] match_q;
    logic [WIDTH-1:0] fail_q;
    logic             anyFail_q;

    // Sample history: slot 0 is the newest sample, slot DEPTH the one being
    // compared against. Enable and mode travel with the data so a change of
    // either applies exactly to the samples taken on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= DEPTH; k++) begin
                hist_q[k] <= '0;
            end
            enSampled_q   <= '0;
            modeSampled_q <= 2'b00;
        end else begin
            hist_q[0] <= chk_if.signal_in;
            for (int k = 1; k <= DEPTH; k++) begin
                hist_q[k] <= hist_q[k-1];
            end
            enSampled_q   <= chk_if.en;
            modeSampled_q <= chk_if.mode;
        end
    end

    // Warm-up counter: saturates at DEPTH+1, at which point the oldest slot
    // holds a real sample rather than the reset zero.
    always_comb begin
        fillCnt_d = fillCnt_q;
        if (fillCnt_q != FillMax) begin
            fillCnt_d = fillCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fillCnt_q <= '0;
        end else begin
            fillCnt_q <= fillCnt_d;
        end
    end

    assign warm = (fillCnt_q == FillMax);
    assign cur  = hist_q[0];
    assign past = hist_q[DEPTH];

    // Per-channel evaluation of the selected sampled-value function.
    always_comb begin
        funcHit = '0;
        case (modeSampled_q)
            2'b00:   funcHit = cur & ~past;
            2'b01:   funcHit = ~cur & past;
            2'b10:   funcHit = ~(cur ^ past);
            default: funcHit = cur ^ past;
        endcase
    end

    // Match and fail are complementary only on enabled channels while warm;
    // otherwise both stay low.
    always_comb begin
        match_d = {WIDTH{warm}} & enSampled_q & funcHit;
        fail_d  = {WIDTH{warm}} & enSampled_q & ~funcHit;
    end

    // Registered result pulses; any_fail is derived from the same next-state
    // fail vector so it lines up with fail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q   <= '0;
            fail_q    <= '0;
            anyFail_q <= 1'b0;
        end else begin
            match_q   <= match_d;
            fail_q    <= fail_d;
            anyFail_q <= |fail_d;
        end
    end

    assign chk_if.match    = match_q;
    assign chk_if.fail     = fail_q;
    assign chk_if.any_fail = anyFail_q;
    assign chk_if.warm     = warm;

`ifdef SAMPLED_VALUE_CHK_STATS_EN
    logic [CNT_W-1:0] failCnt_q;
    logic [CNT_W-1:0] failCnt_d;

    // Fail counter: counts cycles in which the registered any_fail is high,
    // saturating at all-ones; the synchronous clear wins over an increment.
    always_comb begin
        failCnt_d = failCnt_q;
        if (chk_if.cnt_clr) begin
            failCnt_d = '0;
        end else if (anyFail_q && (failCnt_q != {CNT_W{1'b1}})) begin
            failCnt_d = failCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            failCnt_q <= '0;
        end else begin
            failCnt_q <= failCnt_d;
        end
    end

    assign chk_if.fail_cnt = failCnt_q;
`endif

endmodule

// File: tb/tb_sampled_value_chk.sv
// tb_sampled_value_chk
// Drives two checker instances (DEPTH=1 and DEPTH=3, WIDTH=4) with the same
// directed vectors. A model based on an edge-indexed sample log predicts
// every output each cycle; literal expectations pin key points.
// Optional macro: SAMPLED_VALUE_CHK_STATS_EN also exercises fail_cnt (CNT_W=2).
`timescale 1ns/1ps
module tb_sampled_value_chk;

    localparam int Width    = 4;
    localparam int DepthA   = 1;
    localparam int DepthB   = 3;
    localparam int MaxEdges = 256;
`ifdef SAMPLED_VALUE_CHK_STATS_EN
    localparam int CntW     = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [Width-1:0] enVec;
    logic [1:0]       modeVec;
    logic [Width-1:0] sigVec;
    logic             clrBit;

    int checkCnt = 0;
    int passCnt  = 0;

    always #5 clk = ~clk;

`ifdef SAMPLED_VALUE_CHK_STATS_EN
    sampled_value_chk_if #(.WIDTH(Width), .CNT_W(CntW)) ifA ();
    sampled_value_chk_if #(.WIDTH(Width), .CNT_W(CntW)) ifB ();
    sampled_value_chk #(.WIDTH(Width), .DEPTH(DepthA), .CNT_W(CntW)) dutA (
        .clk(clk), .rst(rst), .chk_if(ifA.slave));
    sampled_value_chk #(.WIDTH(Width), .DEPTH(DepthB), .CNT_W(CntW)) dutB (
        .clk(clk), .rst(rst), .chk_if(ifB.slave));
    assign ifA.cnt_clr = clrBit;
    assign ifB.cnt_clr = clrBit;
`else
    sampled_value_chk_if #(.WIDTH(Width)) ifA ();
    sampled_value_chk_if #(.WIDTH(Width)) ifB ();
    sampled_value_chk #(.WIDTH(Width), .DEPTH(DepthA)) dutA (
        .clk(clk), .rst(rst), .chk_if(ifA.slave));
    sampled_value_chk #(.WIDTH(Width), .DEPTH(DepthB)) dutB (
        .clk(clk), .rst(rst), .chk_if(ifB.slave));
`endif

    assign ifA.en        = enVec;
    assign ifA.mode      = modeVec;
    assign ifA.signal_in = sigVec;
    assign ifB.en        = enVec;
    assign ifB.mode      = modeVec;
    assign ifB.signal_in = sigVec;

    // Model state: everything sampled on edge n since reset lives at index n.
    logic [Width-1:0] sLog  [MaxEdges];
    logic [Width-1:0] eLog  [MaxEdges];
    logic [1:0]       mLog  [MaxEdges];
    logic             cLog  [MaxEdges];
    int               edgeCnt;
    logic [Width-1:0] expMatchA, expFailA, expMatchB, expFailB;
    logic             expWarmA, expWarmB;
`ifdef SAMPLED_VALUE_CHK_STATS_EN
    logic [CntW-1:0]  expCntA, expCntB;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCnt++;
        if (actual === expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Wait for the falling edge, then present the next sample set.
    task automatic applyStimulus(input logic [Width-1:0] en, input logic [1:0] mode,
                                 input logic [Width-1:0] sig, input logic clr);
        @(negedge clk);
        enVec   = en;
        modeVec = mode;
        sigVec  = sig;
        clrBit  = clr;
    endtask

    function automatic logic ruleHolds(input logic [1:0] m, input logic cur,
                                       input logic past);
        case (m)
            2'b00:   return cur && !past;
            2'b01:   return !cur && past;
            2'b10:   return cur == past;
            default: return cur != past;
        endcase
    endfunction

    // Outputs after edge t: the evaluation registered at edge t uses the
    // sample of edge t-1 against that of edge t-1-depth, and only counts if
    // the checker was already warm before edge t (t-1 >= depth+1).
    function automatic void expectAfterEdge(input int depth, input int t,
                                            output logic [Width-1:0] mExp,
                                            output logic [Width-1:0] fExp,
                                            output logic wExp);
        mExp = '0;
        fExp = '0;
        wExp = (t >= depth + 1);
        if (t >= depth + 2) begin
            for (int i = 0; i < Width; i++) begin
                if (eLog[t-1][i]) begin
                    if (ruleHolds(mLog[t-1], sLog[t-1][i], sLog[t-1-depth][i]))
                        mExp[i] = 1'b1;
                    else
                        fExp[i] = 1'b1;
                end
            end
        end
    endfunction

    // Model update on every clock edge or reset assertion.
    initial begin
        edgeCnt   = 0;
        expMatchA = '0; expFailA = '0; expWarmA = 1'b0;
        expMatchB = '0; expFailB = '0; expWarmB = 1'b0;
`ifdef SAMPLED_VALUE_CHK_STATS_EN
        expCntA = '0; expCntB = '0;
`endif
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                edgeCnt   = 0;
                expMatchA = '0; expFailA = '0; expWarmA = 1'b0;
                expMatchB = '0; expFailB = '0; expWarmB = 1'b0;
`ifdef SAMPLED_VALUE_CHK_STATS_EN
                expCntA = '0; expCntB = '0;
`endif
            end else begin
                if (edgeCnt < MaxEdges - 1) edgeCnt++;
                sLog[edgeCnt] = sigVec;
                eLog[edgeCnt] = enVec;
                mLog[edgeCnt] = modeVec;
                cLog[edgeCnt] = clrBit;
`ifdef SAMPLED_VALUE_CHK_STATS_EN
                if (cLog[edgeCnt]) expCntA = '0;
                else if ((|expFailA) && expCntA != {CntW{1'b1}}) expCntA = expCntA + 1'b1;
                if (cLog[edgeCnt]) expCntB = '0;
                else if ((|expFailB) && expCntB != {CntW{1'b1}}) expCntB = expCntB + 1'b1;
`endif
                expectAfterEdge(DepthA, edgeCnt, expMatchA, expFailA, expWarmA);
                expectAfterEdge(DepthB, edgeCnt, expMatchB, expFailB, expWarmB);
            end
        end
    end

    // Every falling edge: all outputs of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("mdl matchA", 32'(ifA.match), 32'(expMatchA));
            checkOutput("mdl failA",  32'(ifA.fail),  32'(expFailA));
            checkOutput("mdl anyA",   32'(ifA.any_fail), 32'(|expFailA));
            checkOutput("mdl warmA",  32'(ifA.warm),  32'(expWarmA));
            checkOutput("mdl matchB", 32'(ifB.match), 32'(expMatchB));
            checkOutput("mdl failB",  32'(ifB.fail),  32'(expFailB));
            checkOutput("mdl anyB",   32'(ifB.any_fail), 32'(|expFailB));
            checkOutput("mdl warmB",  32'(ifB.warm),  32'(expWarmB));
`ifdef SAMPLED_VALUE_CHK_STATS_EN
            checkOutput("mdl cntA", 32'(ifA.fail_cnt), 32'(expCntA));
            checkOutput("mdl cntB", 32'(ifB.fail_cnt), 32'(expCntB));
`endif
        end
    end

    // Directed stream used after the reset test: {en, mode, sig, clr}.
    logic [10:0] streamTab [16];

    // Main sequence; comments give the edge number each call samples on.
    initial begin
        streamTab = '{
            {4'hF, 2'b00, 4'h0, 1'b0}, {4'hF, 2'b00, 4'hF, 1'b0},
            {4'hF, 2'b01, 4'h3, 1'b0}, {4'hF, 2'b01, 4'h0, 1'b0},
            {4'hA, 2'b10, 4'h6, 1'b0}, {4'hA, 2'b11, 4'h6, 1'b0},
            {4'h3, 2'b11, 4'h9, 1'b0}, {4'hF, 2'b10, 4'h9, 1'b1},
            {4'hF, 2'b00, 4'h8, 1'b0}, {4'h0, 2'b01, 4'h1, 1'b0},
            {4'hF, 2'b11, 4'hE, 1'b0}, {4'hC, 2'b10, 4'hE, 1'b0},
            {4'hF, 2'b01, 4'h0, 1'b0}, {4'hF, 2'b00, 4'h5, 1'b0},
            {4'h7, 2'b11, 4'hA, 1'b0}, {4'hF, 2'b10, 4'hA, 1'b0}};

        rst = 1'b1; enVec = '0; modeVec = 2'b00; sigVec = '0; clrBit = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset matchA", 32'(ifA.match), 32'h0);
        checkOutput("reset failA",  32'(ifA.fail),  32'h0);
        checkOutput("reset anyA",   32'(ifA.any_fail), 32'h0);
        checkOutput("reset warmA",  32'(ifA.warm),  32'h0);

        applyStimulus(4'hF, 2'b00, 4'h1, 1'b0); rst = 1'b0;        // e1
        applyStimulus(4'hF, 2'b00, 4'h1, 1'b0);                    // e2
        checkOutput("e1 warmA", 32'(ifA.warm), 32'h0);
        applyStimulus(4'hF, 2'b00, 4'h3, 1'b0);                    // e3
        checkOutput("e2 warmA",  32'(ifA.warm),  32'h1);
        checkOutput("e2 failA",  32'(ifA.fail),  32'h0);
        checkOutput("e2 warmB",  32'(ifB.warm),  32'h0);
        applyStimulus(4'hF, 2'b01, 4'h1, 1'b0);                    // e4
        checkOutput("e3 matchA", 32'(ifA.match), 32'h0);
        checkOutput("e3 failA",  32'(ifA.fail),  32'hF);
        applyStimulus(4'hF, 2'b11, 4'h0, 1'b0);                    // e5
        checkOutput("e4 rose matchA", 32'(ifA.match), 32'h2);
        checkOutput("e4 warmB",  32'(ifB.warm),  32'h1);
        checkOutput("e4 matchB", 32'(ifB.match), 32'h0);
        applyStimulus(4'hF, 2'b10, 4'h1, 1'b0);                    // e6
        checkOutput("e5 fell matchA", 32'(ifA.match), 32'h2);
        checkOutput("e5 fell failA",  32'(ifA.fail),  32'hD);
        checkOutput("e5 failB",  32'(ifB.fail),  32'hF);
        applyStimulus(4'h5, 2'b10, 4'hA, 1'b0);                    // e7
        checkOutput("e6 changed matchA", 32'(ifA.match), 32'h1);
        checkOutput("e6 changed matchB", 32'(ifB.match), 32'h1);
        applyStimulus(4'h5, 2'b10, 4'hA, 1'b0);                    // e8
        checkOutput("e7 stable matchA", 32'(ifA.match), 32'hE);
        checkOutput("e7 stable matchB", 32'(ifB.match), 32'hD);
        applyStimulus(4'h5, 2'b10, 4'hA, 1'b0);                    // e9
        checkOutput("e8 en matchA", 32'(ifA.match), 32'h4);
        checkOutput("e8 en failA",  32'(ifA.fail),  32'h1);
        applyStimulus(4'hF, 2'b11, 4'h5, 1'b0);                    // e10
        checkOutput("e9 steady matchA", 32'(ifA.match), 32'h5);
        checkOutput("e9 steady anyA",   32'(ifA.any_fail), 32'h0);
        applyStimulus(4'hF, 2'b10, 4'hA, 1'b0);                    // e11
        applyStimulus(4'hF, 2'b10, 4'hA, 1'b0);                    // e12
        checkOutput("e11 changed matchA", 32'(ifA.match), 32'hF);
        applyStimulus(4'hF, 2'b10, 4'hA, 1'b1);                    // e13, clear
        checkOutput("e12 stable failA", 32'(ifA.fail), 32'hF);
        checkOutput("e12 stable anyA",  32'(ifA.any_fail), 32'h1);
        applyStimulus(4'hF, 2'b10, 4'hA, 1'b0);                    // e14
        checkOutput("e13 matchA", 32'(ifA.match), 32'hF);
`ifdef SAMPLED_VALUE_CHK_STATS_EN
        checkOutput("e13 clr cntA", 32'(ifA.fail_cnt), 32'h0);
`endif

        // Reset in the middle of a cycle while match is high.
        #2 rst = 1'b1;
        #1;
        checkOutput("async matchA", 32'(ifA.match), 32'h0);
        checkOutput("async matchB", 32'(ifB.match), 32'h0);
        checkOutput("async warmA",  32'(ifA.warm),  32'h0);
        checkOutput("async warmB",  32'(ifB.warm),  32'h0);

        applyStimulus(4'hF, 2'b00, 4'h0, 1'b0); rst = 1'b0;        // r1
        applyStimulus(4'hF, 2'b00, 4'h0, 1'b0);                    // r2
        checkOutput("r1 warmA", 32'(ifA.warm), 32'h0);
        applyStimulus(4'hF, 2'b00, 4'h0, 1'b0);                    // r3
        checkOutput("r2 warmA", 32'(ifA.warm), 32'h1);
        checkOutput("r2 warmB", 32'(ifB.warm), 32'h0);
        applyStimulus(4'hF, 2'b00, 4'h0, 1'b0);                    // r4
        checkOutput("r3 warmB", 32'(ifB.warm), 32'h0);
        applyStimulus(4'hF, 2'b00, 4'h0, 1'b0);                    // r5
        checkOutput("r4 warmB", 32'(ifB.warm), 32'h1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(streamTab[i][10:7], streamTab[i][6:5],
                          streamTab[i][4:1], streamTab[i][0]);
        end
        repeat (4) applyStimulus(4'hF, 2'b10, 4'h0, 1'b0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
